// File: rtl/nw_fill_ctrl.sv
// nw_fill_ctrl
// Sequencer for the Needleman-Wunsch matrix fill. It first writes the
// border (row 0, then column 0) of the (N+1)x(N+1) score/arrow RAM. It then
// walks every inner cell (i,j) in row-major order. For each cell it fetches
// the diag, up and left scores, hands them to the max-cell unit, waits for
// its result, and writes {arrow, score} back.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle request to begin a fill (ignored unless idle)
//   busy, done, err   fill in progress / end-of-fill pulse / max-cell timeout
//   final_score       score of cell (N,N), valid from done
//   seqa_addr/char_a  sequence A index i-1 and symbol (1-cycle read latency)
//   seqb_addr/char_b  sequence B index j-1 and symbol (1-cycle read latency)
//   ram_*             score RAM port, synchronous read, data {arrow, score}
//   mx_*              max-cell unit operands, clear, result and valid flag
module nw_fill_ctrl #(
    parameter int N           = 8,
    parameter int ADDR_W      = 8,
    parameter int GAP_SCORE   = -2,
    parameter int MAX_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [8:0]        final_score,
    output logic [3:0]        seqa_addr,
    output logic [3:0]        seqb_addr,
    input  logic [1:0]        char_a,
    input  logic [1:0]        char_b,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [11:0]       ram_wdata,
    input  logic [11:0]       ram_rdata,
    output logic              mx_clr,
    output logic              mx_value,
    output logic [8:0]        mx_diag,
    output logic [8:0]        mx_up,
    output logic [8:0]        mx_lx,
    input  logic [8:0]        mx_max,
    input  logic [2:0]        mx_symbol,
    input  logic              mx_calc
);

    localparam int TO_W = (MAX_TIMEOUT > 1) ? $clog2(MAX_TIMEOUT) : 1;
    localparam logic [3:0]        LAST_IDX = 4'(N);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(N + 1);
    localparam logic [8:0]        GAP9     = 9'(GAP_SCORE);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(MAX_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_ROW, S_INIT_COL, S_RD_D, S_RD_U,
        S_RD_L, S_LAT, S_WAIT, S_WR, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        i_q, j_q;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        acc_q;
    logic [TO_W-1:0]   to_q;
    logic [11:0]       res_q;
    logic [8:0]        diag_q, up_q, lx_q;
    logic              value_q;
    logic              err_q;
    logic [8:0]        final_q;
    logic              lastCell;
    logic              unused_rdata;

    // Only the score field of a neighbour is needed as an operand.
    assign unused_rdata = ^ram_rdata[11:9];
    assign lastCell     = (i_q == LAST_IDX) && (j_q == LAST_IDX);

    assign err         = err_q;
    assign final_score = final_q;
    assign mx_value    = value_q;
    assign mx_diag     = diag_q;
    assign mx_up       = up_q;
    assign mx_lx       = lx_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state plus the outputs that are pure functions of state and
    // counters. addr_q always holds the current cell; the three neighbour
    // addresses are fixed offsets from it, so no multiply is needed.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        mx_clr    = 1'b0;
        seqa_addr = '0;
        seqb_addr = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT_ROW;
            end
            S_INIT_ROW: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = {(j_q == 4'd0) ? 3'b000 : 3'b100, acc_q};
                if (j_q == LAST_IDX) state_d = S_INIT_COL;
            end
            S_INIT_COL: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = {3'b010, acc_q};
                if (i_q == LAST_IDX) state_d = S_RD_D;
            end
            S_RD_D, S_RD_U, S_RD_L, S_LAT, S_WAIT, S_WR: begin
                busy      = 1'b1;
                seqa_addr = i_q - 4'd1;
                seqb_addr = j_q - 4'd1;
                case (state_q)
                    S_RD_D: begin
                        ram_addr = addr_q - STRIDE - ADDR_W'(1);
                        state_d  = S_RD_U;
                    end
                    S_RD_U: begin
                        ram_addr = addr_q - STRIDE;
                        state_d  = S_RD_L;
                    end
                    S_RD_L: begin
                        ram_addr = addr_q - ADDR_W'(1);
                        state_d  = S_LAT;
                    end
                    S_LAT: begin
                        mx_clr  = 1'b1;
                        state_d = S_WAIT;
                    end
                    S_WAIT: begin
                        if (mx_calc)               state_d = S_WR;
                        else if (to_q == TO_LAST)  state_d = S_DONE;
                    end
                    default: begin
                        ram_we    = 1'b1;
                        ram_addr  = addr_q;
                        ram_wdata = res_q;
                        state_d   = lastCell ? S_DONE : S_RD_D;
                    end
                endcase
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: border accumulator, cell counters and address, operand
    // latches, WAIT timeout and the captured max-cell result. The result is
    // captured on the accepting WAIT cycle so the write does not depend on
    // the unit holding its outputs for another cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q     <= '0;
            j_q     <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            to_q    <= '0;
            res_q   <= '0;
            diag_q  <= '0;
            up_q    <= '0;
            lx_q    <= '0;
            value_q <= 1'b0;
            err_q   <= 1'b0;
            final_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        i_q    <= '0;
                        j_q    <= '0;
                        addr_q <= '0;
                        acc_q  <= '0;
                        err_q  <= 1'b0;
                    end
                end
                S_INIT_ROW: begin
                    if (j_q == LAST_IDX) begin
                        i_q    <= 4'd1;
                        addr_q <= STRIDE;
                        acc_q  <= GAP9;
                    end else begin
                        j_q    <= j_q + 4'd1;
                        addr_q <= addr_q + ADDR_W'(1);
                        acc_q  <= acc_q + GAP9;
                    end
                end
                S_INIT_COL: begin
                    if (i_q == LAST_IDX) begin
                        i_q    <= 4'd1;
                        j_q    <= 4'd1;
                        addr_q <= STRIDE + ADDR_W'(1);
                    end else begin
                        i_q    <= i_q + 4'd1;
                        addr_q <= addr_q + STRIDE;
                        acc_q  <= acc_q + GAP9;
                    end
                end
                S_RD_U: diag_q <= ram_rdata[8:0];
                S_RD_L: up_q   <= ram_rdata[8:0];
                S_LAT: begin
                    lx_q    <= ram_rdata[8:0];
                    value_q <= (char_a == char_b);
                    to_q    <= '0;
                end
                S_WAIT: begin
                    if (mx_calc) begin
                        res_q <= {mx_symbol, mx_max};
                    end else begin
                        to_q <= to_q + TO_W'(1);
                        if (to_q == TO_LAST) err_q <= 1'b1;
                    end
                end
                S_WR: begin
                    if (lastCell) final_q <= res_q[8:0];
                    // Stepping from (i,N) to (i+1,1) moves the address by 2.
                    if (j_q == LAST_IDX) begin
                        j_q    <= 4'd1;
                        i_q    <= i_q + 4'd1;
                        addr_q <= addr_q + ADDR_W'(2);
                    end else begin
                        j_q    <= j_q + 4'd1;
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_fill_ctrl.sv
// tb_nw_fill_ctrl
// Self-checking bench for nw_fill_ctrl with N=2. It provides a RAM model,
// sequence buffers and a max-cell unit model with a programmable response
// delay. A dynamic-programming reference builds the expected write stream
// for every fill.
module tb_nw_fill_ctrl;

    localparam int N   = 2;
    localparam int AW  = 8;
    localparam int GAP = -2;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, err;
    logic [8:0]    final_score;
    logic [3:0]    seqa_addr, seqb_addr;
    logic [1:0]    char_a, char_b;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [11:0]   ram_wdata;
    logic [11:0]   ram_rdata;
    logic          mx_clr, mx_value;
    logic [8:0]    mx_diag, mx_up, mx_lx, mx_max;
    logic [2:0]    mx_symbol;
    logic          mx_calc;

    nw_fill_ctrl #(.N(N), .ADDR_W(AW), .GAP_SCORE(GAP), .MAX_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .err(err), .final_score(final_score),
        .seqa_addr(seqa_addr), .seqb_addr(seqb_addr),
        .char_a(char_a), .char_b(char_b),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .mx_clr(mx_clr), .mx_value(mx_value),
        .mx_diag(mx_diag), .mx_up(mx_up), .mx_lx(mx_lx),
        .mx_max(mx_max), .mx_symbol(mx_symbol), .mx_calc(mx_calc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [11:0]   data;
        bit            isCell;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    wr_t         expQ[$];
    int          cellQ[$];
    int          wQ[$];
    int          modelScore [0:N][0:N];
    int          expFinal;
    bit          expErr;
    int          busyCount, clrCount, doneCount, lastWr, wSum;
    int          h0, h1, h2;
    logic [11:0] mem [0:255];
    logic [1:0]  seqA [0:15];
    logic [1:0]  seqB [0:15];
    int          calcMode = 1;
    int          calcDelay = 0;
    int          sinceClr = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    function automatic logic [11:0] pack(input logic [2:0] a, input int s);
        logic [8:0] s9;
        s9 = s[8:0];
        return {a, s9};
    endfunction

    // Max-cell decision: highest candidate wins, ties resolved diag, up, left.
    function automatic logic [11:0] bestOf(input int d, input int u, input int l);
        if (d >= u && d >= l) return pack(3'b001, d);
        else if (u >= l)      return pack(3'b010, u);
        else                  return pack(3'b100, l);
    endfunction

    // Score RAM and sequence buffers, all with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        char_a    <= seqA[seqa_addr];
        char_b    <= seqB[seqb_addr];
    end

    // Max-cell unit model. Modes: 0 random delay, 1 immediate, 2 never
    // answers, 3 valid flag stuck high.
    always @(posedge clk) begin
        int nd;
        if (mx_clr) begin
            nd = (calcMode == 0) ? int'($urandom_range(0, 3)) : 0;
            calcDelay <= nd;
            sinceClr  <= 0;
            wQ.push_back(nd + 1);
            wSum += nd + 1;
        end else if (sinceClr < 100000) begin
            sinceClr <= sinceClr + 1;
        end
    end

    assign mx_calc = (calcMode == 3) ? 1'b1 :
                     (calcMode == 2) ? 1'b0 : (sinceClr >= calcDelay);

    always_comb begin
        logic [11:0] r;
        r = bestOf(int'($signed(mx_diag)) + (mx_value ? 1 : -1),
                   int'($signed(mx_up)) + GAP,
                   int'($signed(mx_lx)) + GAP);
        mx_symbol = r[11:9];
        mx_max    = r[8:0];
    end

    // Reference fill: border then inner cells in row-major order.
    task automatic buildModel(input bit timeoutRun);
        logic [11:0] r;
        expQ.delete();
        cellQ.delete();
        wQ.delete();
        for (int j = 0; j <= N; j++) begin
            modelScore[0][j] = j * GAP;
            expQ.push_back('{AW'(j), pack((j == 0) ? 3'b000 : 3'b100, j * GAP), 1'b0});
        end
        for (int i = 1; i <= N; i++) begin
            modelScore[i][0] = i * GAP;
            expQ.push_back('{AW'(i * (N + 1)), pack(3'b010, i * GAP), 1'b0});
        end
        for (int i = 1; i <= N; i++) begin
            for (int j = 1; j <= N; j++) begin
                r = bestOf(modelScore[i-1][j-1] + ((seqA[i-1] == seqB[j-1]) ? 1 : -1),
                           modelScore[i-1][j] + GAP,
                           modelScore[i][j-1] + GAP);
                modelScore[i][j] = int'($signed(r[8:0]));
                cellQ.push_back(i * (N + 1) + j);
                if (!timeoutRun) expQ.push_back('{AW'(i * (N + 1) + j), r, 1'b1});
            end
        end
        expFinal = modelScore[N][N];
    endtask

    always @(posedge clk) cycle++;

    // Compare process: every write against the reference stream, neighbour
    // read order at each clear, per-cell cycle count, and done status.
    always @(negedge clk) begin
        wr_t w;
        int  c;
        if (!rst) begin
            if (busy) busyCount++;
            if (mx_clr) begin
                clrCount++;
                if (cellQ.size() == 0) begin
                    failNow("clr_without_cell");
                end else begin
                    c = cellQ[0];
                    checkOutput("read_order", {h0, h1, h2}, {c - N - 2, c - N - 1, c - 1});
                end
            end
            h0 = h1;
            h1 = h2;
            h2 = int'(ram_addr);
            if (ram_we) begin
                if (expQ.size() == 0) begin
                    failNow("unexpected_write");
                end else begin
                    w = expQ.pop_front();
                    checkOutput("write_addr", ram_addr, w.addr);
                    checkOutput("write_data", ram_wdata, w.data);
                    if (w.isCell) begin
                        if (cellQ.size() > 0) void'(cellQ.pop_front());
                        checkOutput("cell_cycles", cycle - lastWr,
                                    5 + ((wQ.size() > 0) ? wQ.pop_front() : 100));
                    end
                end
                lastWr = cycle;
            end
            if (done) begin
                doneCount++;
                checkOutput("done_err", err, expErr);
                checkOutput("done_busy", busy, 1'b0);
                if (!expErr) checkOutput("final_score", final_score, expFinal[8:0]);
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctl"}, {busy, done, err, ram_we, mx_clr, mx_value}, 6'd0);
        checkOutput({tag, "_addr"}, {ram_addr, seqa_addr, seqb_addr, final_score}, 25'd0);
        checkOutput({tag, "_data"}, {mx_diag, mx_up, mx_lx, ram_wdata}, 48'd0);
    endtask

    // One fill with the given unit mode; optionally pulses start mid-fill
    // and in the DONE cycle, both of which must be ignored.
    task automatic applyStimulus(input int mode, input bit timeoutRun,
                                 input bit midStart, input bit doneStart);
        int k;
        calcMode = mode;
        buildModel(timeoutRun);
        expErr    = timeoutRun;
        busyCount = 0;
        clrCount  = 0;
        doneCount = 0;
        wSum      = 0;
        lastWr    = cycle;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checkOutput("busy_after_start", busy, 1'b1);
        checkOutput("err_after_start", err, 1'b0);
        for (k = 0; k < 3000 && doneCount == 0; k++) begin
            @(posedge clk); #1;
            start = (midStart && k == 15) || (doneStart && done);
        end
        start = 1'b0;
        if (doneCount == 0) failNow("done_timeout");
        repeat (4) @(posedge clk);
        #1;
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("done_count", doneCount, 1);
        checkOutput("writes_left", expQ.size(), 0);
        checkOutput("clr_count", clrCount, timeoutRun ? 1 : N * N);
        checkOutput("busy_cycles", busyCount,
                    timeoutRun ? (2 * N + 1 + 4 + TMO) : (2 * N + 1 + 5 * N * N + wSum));
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 12'h0;
        for (int a = 0; a < 16; a++) begin
            seqA[a] = 2'd0;
            seqB[a] = 2'd0;
        end
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkResetOutputs("reset");
        rst = 1'b0;

        // Directed fill: A = B = "AC", unit answers in the first WAIT cycle.
        seqA[0] = 2'd0; seqA[1] = 2'd1;
        seqB[0] = 2'd0; seqB[1] = 2'd1;
        applyStimulus(1, 1'b0, 1'b0, 1'b0);
        checkOutput("cell11", mem[4], 12'h201);
        checkOutput("cell12", mem[5], 12'h9FF);
        checkOutput("cell21", mem[7], 12'h5FF);
        checkOutput("cell22", mem[8], 12'h202);
        checkOutput("final_lit", final_score, 9'd2);

        // Reset in the middle of the border row.
        buildModel(1'b0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        #1 checkResetOutputs("midrst");
        @(posedge clk); #1 checkResetOutputs("midrst_hold");
        rst = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 1'b0);

        // Random sequences with random unit latency.
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < N; a++) begin
                seqA[a] = 2'($urandom_range(0, 3));
                seqB[a] = 2'($urandom_range(0, 3));
            end
            applyStimulus(0, 1'b0, 1'b0, 1'b0);
        end

        // Timeout at cell (1,1): border only, err set.
        applyStimulus(2, 1'b1, 1'b0, 1'b0);
        checkOutput("err_held", err, 1'b1);
        checkOutput("border0", mem[0], 12'h000);
        checkOutput("border1", mem[1], 12'h9FE);
        checkOutput("border2", mem[2], 12'h9FC);
        checkOutput("border3", mem[3], 12'h5FE);
        checkOutput("border6", mem[6], 12'h5FC);

        // Next start clears err (checked inside), then stuck valid flag with
        // start pulses mid-fill and in the DONE cycle.
        applyStimulus(0, 1'b0, 1'b0, 1'b0);
        seqA[0] = 2'd3; seqA[1] = 2'd2;
        seqB[0] = 2'd2; seqB[1] = 2'd3;
        applyStimulus(3, 1'b0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/nw_fill_ctrl.md
Name: nw_fill_ctrl

Overview:
- Sequencer for Needleman-Wunsch matrix fill.
- Initialises row 0 and column 0 of the (N+1)x(N+1) score/arrow RAM.
- Then walks cells (i,j), i,j = 1..N, in row-major order. For each cell it fetches the diag, up and left scores, drives the max-cell unit, waits for its `calculated` flag, and writes {arrow, score} back to RAM.
- Sits between sequence buffers, score RAM and the max-cell unit; the traceback block consumes its `done`.

Parameters:
- N, 8: sequence length (both sequences), 1..15.
- ADDR_W, 8: RAM address width; must satisfy (N+1)^2 <= 2^ADDR_W.
- GAP_SCORE, -2: gap penalty used for border initialisation; must equal the max-cell unit's gap_score.
- MAX_TIMEOUT, 8: cycles allowed in WAIT before abort.

Ports:
- Clocking and control: clk in 1 clock; rst in 1 async active-high reset; start in 1 one-cycle request to begin a fill.
- Status: busy out 1 high from accepted start until done; done out 1 one-cycle pulse at end of fill; err out 1 set on max-cell timeout, cleared by next accepted start; final_score out 9 signed score of cell(N,N), valid from done.
- Sequence buffers: seqa_addr out 4 index i-1 into sequence A; seqb_addr out 4 index j-1 into sequence B; char_a in 2 A symbol, 1-cycle read latency; char_b in 2 B symbol, 1-cycle read latency.
- Score RAM: ram_addr out ADDR_W address; ram_we out 1 write enable; ram_wdata out 12 {arrow[2:0], score[8:0]}; ram_rdata in 12 sync read data, valid the cycle after ram_addr.
- Max-cell unit: mx_clr out 1 clears the unit (drives its rst); mx_value out 1 char match flag; mx_diag, mx_up, mx_lx out 9 signed operand scores; mx_max in 9 signed result; mx_symbol in 3 arrow (100 left, 010 up, 001 diag); mx_calc in 1 result valid.

Behaviour:
- Reset: all state zero (state IDLE); busy, done, err, ram_we, mx_clr, mx_value = 0; ram_addr, seqa_addr, seqb_addr, final_score, mx_diag, mx_up, mx_lx = 0; ram_wdata = 0.
- Address of (i,j) = i*(N+1)+j, maintained incrementally; no multiplier.
- IDLE: start=1 moves to INIT_ROW, sets busy=1, clears err. start while busy is ignored.
- INIT_ROW: one write per cycle for j=0..N at addr j.
  - Data {001? no: j=0 -> 000, else 100, j*GAP_SCORE}: cell(0,0) arrow 000, other cells arrow 100 (left).
  - Score via running accumulator.
  - After j=N -> INIT_COL.
- INIT_COL: one write per cycle for i=1..N at addr i*(N+1), score i*GAP_SCORE, arrow 010 (up). After i=N -> RD_D with i=j=1.
- Per-cell sequence, minimum 6 cycles:
  - RD_D: ram_addr = diag addr; drive seqa_addr=i-1, seqb_addr=j-1.
  - RD_U: ram_addr = up addr; latch mx_diag = rdata[8:0].
  - RD_L: ram_addr = left addr; latch mx_up.
  - LAT: latch mx_lx; mx_value = (char_a == char_b); mx_clr=1 for exactly this cycle.
  - WAIT: operands held stable; leave when mx_calc=1. If MAX_TIMEOUT cycles elapse without mx_calc, set err=1 and go to DONE; RAM is left partially filled.
  - WR: ram_we=1, addr = cell, wdata = {mx_symbol, mx_max}. Then advance j; on j=N, set j=1 and i+1. After (N,N), latch final_score = mx_max and go to DONE.
- mx_calc is ignored outside WAIT; a value held over from before mx_clr must not be accepted, hence the clear in LAT.
- ram_we is high only in INIT_ROW, INIT_COL and WR.
- DONE: done=1 for one cycle, busy=0 -> IDLE. If start is asserted in the DONE cycle it is ignored.
- Scores are 9-bit signed; the controller does no arithmetic on scores beyond border init. Init values are computed in 9-bit two's complement (N=15, GAP=-2 -> -30, no overflow).
- Async rst at any time returns to IDLE immediately; outputs take reset values, and RAM content is undefined thereafter.
- Total cycles for a clean run: 1 + (N+1) + N + N^2*(5 + W) + 1, where W >= 1 is the number of WAIT cycles.

Test Plan:
- Reset value check: assert rst mid-INIT_ROW -> next cycle busy=0, ram_we=0, all outputs 0; a later start runs a full fill from j=0.
- Border init, N=2, GAP=-2: writes addr0={000,0}, 1={100,-2}, 2={100,-4}, 3={010,-2}, 6={010,-4}, in that order, one per cycle.
- Full fill, N=2, A="AC" (00,01), B="AC", behavioural max-cell with 1-cycle latency:
  - cell(1,1)={001,1}, (1,2)={100,-1}, (2,1)={010,-1}, (2,2)={001,2}.
  - final_score=2, done pulse once, err=0.
- Timing: with mx_calc asserted the cycle after LAT, each cell occupies exactly 6 cycles. mx_clr is high exactly one cycle per cell; diag/up/lx addresses appear in order D, U, L.
- Timeout: hold mx_calc=0 at cell(1,1) -> after 8 WAIT cycles err=1, done pulses, no WR for that cell. The next start clears err.
- Stale flag and start-while-busy: mx_calc held 1 constantly -> still exactly one write per cell, after LAT. start pulsed during fill -> ignored, no restart, single done.
